// File: rtl/map_recovery_ctrl.sv
// Commit filter between the ROB retire port and the AMT, plus the mispredict
// recovery sequencer that copies committed AMT mappings into the speculative RAT.
module map_recovery_ctrl #(
   parameter int ARCH_REGS    = 64,
   parameter int PHYS_REGS    = 128,
   parameter int COMMIT_WIDTH = 2,
   parameter int COPY_WIDTH   = 8,
   parameter int ZERO_REG_EN  = 1
) (
   input  logic                                                clock,
   input  logic                                                reset,
   input  logic [COMMIT_WIDTH-1:0]                             rob_commit_valid_i,
   input  logic [COMMIT_WIDTH-1:0][$clog2(ARCH_REGS)-1:0]      rob_commit_arch_i,
   input  logic [COMMIT_WIDTH-1:0][$clog2(PHYS_REGS)-1:0]      rob_commit_phys_i,
   input  logic                                                mispredict_i,
   input  logic [ARCH_REGS-1:0][$clog2(PHYS_REGS)-1:0]         amt_snapshot_i,
   output logic [COMMIT_WIDTH-1:0]                             amt_commit_valid_o,
   output logic [COMMIT_WIDTH-1:0][$clog2(ARCH_REGS)-1:0]      amt_commit_arch_o,
   output logic [COMMIT_WIDTH-1:0][$clog2(PHYS_REGS)-1:0]      amt_commit_phys_o,
   output logic [COPY_WIDTH-1:0]                               rat_wr_valid_o,
   output logic [COPY_WIDTH-1:0][$clog2(ARCH_REGS)-1:0]        rat_wr_idx_o,
   output logic [COPY_WIDTH-1:0][$clog2(PHYS_REGS)-1:0]        rat_wr_phys_o,
   output logic                                                flush_o,
   output logic                                                commit_stall_o,
   output logic                                                busy_o,
   output logic                                                done_o
);

   localparam int AW       = $clog2(ARCH_REGS);
   localparam int N_CHUNKS = (ARCH_REGS + COPY_WIDTH - 1) / COPY_WIDTH;
   localparam int CNTW     = $clog2(N_CHUNKS) + 1;
   localparam int IDXW     = $clog2(N_CHUNKS * COPY_WIDTH + 1);
   localparam logic [CNTW-1:0] LAST_CHUNK = CNTW'(N_CHUNKS - 1);

   typedef enum logic [1:0] {IDLE, FLUSH, COPY, DONE} state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [CNTW-1:0]         r_cnt;
   logic [CNTW-1:0]         w_cnt_next;
   logic [COMMIT_WIDTH-1:0] w_keep;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // mispredict_i is only looked at in IDLE, so it cannot restart or extend recovery
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         IDLE:    if (mispredict_i) w_state_next = FLUSH;
         FLUSH: begin
            w_cnt_next   = '0;
            w_state_next = COPY;
         end
         COPY: begin
            w_cnt_next = r_cnt + CNTW'(1);
            if (r_cnt == LAST_CHUNK) w_state_next = DONE;
         end
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // A slot survives only if no younger valid slot in the group writes the same register
   for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_filter
      logic w_overwritten;
      logic w_zero_drop;

      always_comb begin
         w_overwritten = 1'b0;
         for (int j = gi + 1; j < COMMIT_WIDTH; j++) begin
            if (rob_commit_valid_i[j] && (rob_commit_arch_i[j] == rob_commit_arch_i[gi]))
               w_overwritten = 1'b1;
         end
      end

      assign w_zero_drop = (ZERO_REG_EN != 0) && (rob_commit_arch_i[gi] == '0);
      assign w_keep[gi]  = rob_commit_valid_i[gi] && !w_overwritten && !w_zero_drop;
   end

   assign amt_commit_valid_o = (!reset && (r_state == IDLE)) ? w_keep : '0;
   assign amt_commit_arch_o  = reset ? '0 : rob_commit_arch_i;
   assign amt_commit_phys_o  = reset ? '0 : rob_commit_phys_i;

   // Lanes past the last architectural register in the final chunk are masked and zeroed
   for (genvar gi = 0; gi < COPY_WIDTH; gi++) begin : g_lane
      logic [IDXW-1:0] w_idx;
      logic            w_in_range;

      assign w_idx      = IDXW'(r_cnt) * IDXW'(COPY_WIDTH) + IDXW'(gi);
      assign w_in_range = (r_state == COPY) && (w_idx < IDXW'(ARCH_REGS));

      assign rat_wr_valid_o[gi] = w_in_range;
      assign rat_wr_idx_o[gi]   = w_in_range ? w_idx[AW-1:0] : '0;
      assign rat_wr_phys_o[gi]  = w_in_range ? amt_snapshot_i[w_idx[AW-1:0]] : '0;
   end

   assign flush_o        = (r_state == FLUSH);
   assign done_o         = (r_state == DONE);
   assign busy_o         = (r_state != IDLE);
   assign commit_stall_o = (r_state != IDLE);

endmodule

// File: tb/tb_map_recovery_ctrl.sv
// Directed bench for map_recovery_ctrl: commit filter, full and partial-chunk
// recovery, ignored mispredicts and asynchronous abort, with a RAT-write scoreboard.
module tb_map_recovery_ctrl;

   localparam int AR = 64;

   typedef struct {
      int idx;
      int phys;
   } wr_t;

   logic              clock = 1'b0;
   logic              reset;
   logic [1:0]        cv;
   logic [1:0][5:0]   ca;
   logic [1:0][6:0]   cp;
   logic              mp_a;
   logic              mp_b;
   logic [AR-1:0][6:0] amt;

   logic [1:0]        a_acv,  b_acv;
   logic [1:0][5:0]   a_aca,  b_aca;
   logic [1:0][6:0]   a_acp,  b_acp;
   logic [7:0]        a_rv;
   logic [7:0][5:0]   a_ridx;
   logic [7:0][6:0]   a_rph;
   logic [5:0]        b_rv;
   logic [5:0][5:0]   b_ridx;
   logic [5:0][6:0]   b_rph;
   logic              a_flush, a_stall, a_busy, a_done;
   logic              b_flush, b_stall, b_busy, b_done;

   int  n_chk = 0;
   int  n_err = 0;
   wr_t exp_q[$];

   always #5 clock = ~clock;

   map_recovery_ctrl #(.ARCH_REGS(64), .PHYS_REGS(128), .COMMIT_WIDTH(2), .COPY_WIDTH(8), .ZERO_REG_EN(1)) u_dut_a (
      .clock(clock), .reset(reset),
      .rob_commit_valid_i(cv), .rob_commit_arch_i(ca), .rob_commit_phys_i(cp),
      .mispredict_i(mp_a), .amt_snapshot_i(amt),
      .amt_commit_valid_o(a_acv), .amt_commit_arch_o(a_aca), .amt_commit_phys_o(a_acp),
      .rat_wr_valid_o(a_rv), .rat_wr_idx_o(a_ridx), .rat_wr_phys_o(a_rph),
      .flush_o(a_flush), .commit_stall_o(a_stall), .busy_o(a_busy), .done_o(a_done)
   );

   map_recovery_ctrl #(.ARCH_REGS(64), .PHYS_REGS(128), .COMMIT_WIDTH(2), .COPY_WIDTH(6), .ZERO_REG_EN(1)) u_dut_b (
      .clock(clock), .reset(reset),
      .rob_commit_valid_i(cv), .rob_commit_arch_i(ca), .rob_commit_phys_i(cp),
      .mispredict_i(mp_b), .amt_snapshot_i(amt),
      .amt_commit_valid_o(b_acv), .amt_commit_arch_o(b_aca), .amt_commit_phys_o(b_acp),
      .rat_wr_valid_o(b_rv), .rat_wr_idx_o(b_ridx), .rat_wr_phys_o(b_rph),
      .flush_o(b_flush), .commit_stall_o(b_stall), .busy_o(b_busy), .done_o(b_done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic grab(input int sel, output logic [1:0] acv, output logic [7:0] rv,
                       output logic [7:0][5:0] ridx, output logic [7:0][6:0] rph,
                       output logic flush, output logic stall, output logic busy,
                       output logic done);
      rv   = '0;
      ridx = '0;
      rph  = '0;
      if (sel == 0) begin
         acv = a_acv; rv = a_rv; ridx = a_ridx; rph = a_rph;
         flush = a_flush; stall = a_stall; busy = a_busy; done = a_done;
      end else begin
         acv = b_acv; rv = {2'b00, b_rv};
         for (int k = 0; k < 6; k++) begin
            ridx[k] = b_ridx[k];
            rph[k]  = b_rph[k];
         end
         flush = b_flush; stall = b_stall; busy = b_busy; done = b_done;
      end
   endtask

   // Mispredict with arch7->p99 commit, then follow the fixed recovery timeline
   task automatic run_recovery(input int sel, input bit extra_mp);
      int              n_chunks, lanes;
      logic [1:0]      acv;
      logic [7:0]      rv, exp_rv;
      logic [7:0][5:0] ridx;
      logic [7:0][6:0] rph;
      logic            flush, stall, busy, done;
      wr_t             e;
      n_chunks = (sel != 0) ? 11 : 8;
      lanes    = (sel != 0) ? 6 : 8;
      exp_q.delete();

      @(negedge clock);
      if (sel != 0) mp_b = 1'b1; else mp_a = 1'b1;
      cv = 2'b01; ca[0] = 6'd7; cp[0] = 7'd99; ca[1] = 6'd0; cp[1] = 7'd0;
      #1;
      grab(sel, acv, rv, ridx, rph, flush, stall, busy, done);
      chk("mp_commit_pass", 64'(acv), 64'(2'b01));
      chk("mp_no_stall", 64'(stall), 64'(1'b0));
      $display("sel=%0d mispredict issued with commit arch7->p99", sel);

      for (int cyc = 1; cyc <= n_chunks + 2; cyc++) begin
         @(negedge clock);
         mp_a = 1'b0; mp_b = 1'b0; cv = 2'b00;
         if (cyc == 1) begin
            amt[7] = 7'd99;
            for (int i = 0; i < AR; i++) exp_q.push_back('{idx: i, phys: int'(amt[i])});
         end
         if (extra_mp && cyc == 4) begin
            if (sel != 0) mp_b = 1'b1; else mp_a = 1'b1;
            cv = 2'b11; ca[0] = 6'd10; ca[1] = 6'd11;
         end
         #1;
         grab(sel, acv, rv, ridx, rph, flush, stall, busy, done);
         chk("flush", 64'(flush), 64'(cyc == 1));
         chk("done", 64'(done), 64'(cyc == n_chunks + 2));
         chk("stall", 64'(stall), 64'(1'b1));
         chk("busy", 64'(busy), 64'(1'b1));
         chk("commit_blocked", 64'(acv), 64'(2'b00));
         exp_rv = '0;
         if (cyc >= 2 && cyc <= n_chunks + 1)
            for (int k = 0; k < lanes; k++)
               if ((cyc - 2) * lanes + k < AR) exp_rv[k] = 1'b1;
         chk("rat_valid", 64'(rv), 64'(exp_rv));
         for (int k = 0; k < lanes; k++) begin
            if (rv[k]) begin
               chk("sb_nonempty", 64'(exp_q.size() != 0), 64'(1'b1));
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("rat_idx", 64'(ridx[k]), 64'(e.idx));
                  chk("rat_phys", 64'(rph[k]), 64'(e.phys));
               end
            end else begin
               chk("lane_idx_zero", 64'(ridx[k]), 64'(0));
               chk("lane_phys_zero", 64'(rph[k]), 64'(0));
            end
         end
         $display("sel=%0d cyc=%0d flush=%0b done=%0b stall=%0b rat_valid=%02h", sel, cyc, flush, done, stall, rv);
      end
      chk("sb_empty", 64'(exp_q.size()), 64'(0));

      @(negedge clock);
      cv = 2'b01; ca[0] = 6'd5; cp[0] = 7'd70;
      #1;
      grab(sel, acv, rv, ridx, rph, flush, stall, busy, done);
      chk("post_stall", 64'(stall), 64'(1'b0));
      chk("post_busy", 64'(busy), 64'(1'b0));
      chk("post_commit", 64'(acv), 64'(2'b01));
      $display("sel=%0d post-recovery commit valid=%02b", sel, acv);
      @(negedge clock);
      cv = 2'b00;
   endtask

   initial begin
      reset = 1'b1;
      cv = '0; ca = '0; cp = '0; mp_a = 1'b0; mp_b = 1'b0;
      for (int i = 0; i < AR; i++) amt[i] = 7'(i);

      // Reset holds every output low even with a valid commit presented
      @(negedge clock);
      cv = 2'b01; ca[0] = 6'd5; cp[0] = 7'd70;
      #1;
      chk("rst_acv_a", 64'(a_acv), 64'(0));
      chk("rst_acv_b", 64'(b_acv), 64'(0));
      chk("rst_aca", 64'(a_aca), 64'(0));
      chk("rst_stall", 64'(a_stall), 64'(0));
      chk("rst_busy", 64'(a_busy), 64'(0));
      chk("rst_flush", 64'(a_flush), 64'(0));
      chk("rst_done", 64'(a_done), 64'(0));
      chk("rst_rat_valid", 64'(a_rv), 64'(0));
      $display("reset held: acv=%02b busy=%0b", a_acv, a_busy);

      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("idle_commit_a", 64'(a_acv), 64'(2'b01));
      chk("idle_commit_b", 64'(b_acv), 64'(2'b01));
      chk("pass_arch", 64'(a_aca[0]), 64'(6'd5));
      chk("pass_phys", 64'(a_acp[0]), 64'(7'd70));
      $display("idle commit arch5->p70 valid=%02b", a_acv);

      @(negedge clock);
      cv = 2'b11; ca[0] = 6'd3; cp[0] = 7'd40; ca[1] = 6'd3; cp[1] = 7'd41;
      #1;
      chk("waw_filter", 64'(a_acv), 64'(2'b10));
      $display("waw arch3/arch3 valid=%02b", a_acv);

      @(negedge clock);
      cv = 2'b01; ca[0] = 6'd3; ca[1] = 6'd3;
      #1;
      chk("waw_invalid_younger", 64'(a_acv), 64'(2'b01));
      $display("waw with invalid younger valid=%02b", a_acv);

      @(negedge clock);
      cv = 2'b11; ca[0] = 6'd0; ca[1] = 6'd9;
      #1;
      chk("zero_reg_drop", 64'(a_acv), 64'(2'b10));
      $display("zero reg slot0 valid=%02b", a_acv);

      @(negedge clock);
      cv = 2'b11; ca[0] = 6'd0; ca[1] = 6'd0;
      #1;
      chk("zero_reg_both", 64'(a_acv), 64'(2'b00));

      @(negedge clock);
      cv = 2'b11; ca[0] = 6'd4; ca[1] = 6'd9;
      #1;
      chk("distinct_regs", 64'(a_acv), 64'(2'b11));
      $display("distinct regs valid=%02b", a_acv);

      @(negedge clock);
      cv = 2'b00;

      run_recovery(0, 1'b0);
      run_recovery(1, 1'b0);
      run_recovery(0, 1'b1);

      // Abort in the third COPY cycle with an asynchronous mid-cycle reset
      @(negedge clock);
      mp_a = 1'b1; cv = 2'b01; ca[0] = 6'd7; cp[0] = 7'd99;
      @(negedge clock);
      mp_a = 1'b0; cv = 2'b00;
      repeat (3) @(negedge clock);
      #1;
      chk("abort_pre_valid", 64'(a_rv), 64'(8'hff));
      chk("abort_pre_idx", 64'(a_ridx[0]), 64'(16));
      cv = 2'b01; ca[0] = 6'd5;
      #1 reset = 1'b1;
      #1;
      chk("abort_rat_valid", 64'(a_rv), 64'(0));
      chk("abort_busy", 64'(a_busy), 64'(0));
      chk("abort_stall", 64'(a_stall), 64'(0));
      chk("abort_acv", 64'(a_acv), 64'(0));
      $display("async abort: rat_valid=%02h busy=%0b", a_rv, a_busy);
      @(negedge clock);
      reset = 1'b0; cv = 2'b00;

      run_recovery(0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/map_recovery_ctrl.md
Name: map_recovery_ctrl

Overview:
- Sits between the ROB retire port and the architectural map table (AMT).
- Filters each commit group before it reaches the AMT: drops earlier same-register writes and zero-register writes.
- On a retired mispredicted branch, sequences recovery: one-cycle pipeline flush, then copies the committed AMT mappings into the speculative RAT, COPY_WIDTH entries per cycle.
- Stalls commit for the whole recovery.

Parameters:
ARCH_REGS, 64, number of architectural registers
PHYS_REGS, 128, number of physical registers
COMMIT_WIDTH, 2, commit slots per cycle
COPY_WIDTH, 8, RAT entries written per copy cycle (1..ARCH_REGS)
ZERO_REG_EN, 1, when 1, commits to arch reg 0 are dropped

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
rob_commit_valid_i  in  COMMIT_WIDTH  per-slot commit valid; slot 0 is oldest
rob_commit_arch_i  in  COMMIT_WIDTH x clog2(ARCH_REGS)  committed arch reg per slot
rob_commit_phys_i  in  COMMIT_WIDTH x clog2(PHYS_REGS)  committed phys reg per slot
mispredict_i  in  1  the current commit group contains a retiring mispredicted branch
amt_snapshot_i  in  ARCH_REGS x clog2(PHYS_REGS)  full AMT contents
amt_commit_valid_o  out  COMMIT_WIDTH  filtered commit valid to the AMT
amt_commit_arch_o  out  COMMIT_WIDTH x clog2(ARCH_REGS)  pass-through of rob_commit_arch_i
amt_commit_phys_o  out  COMMIT_WIDTH x clog2(PHYS_REGS)  pass-through of rob_commit_phys_i
rat_wr_valid_o  out  COPY_WIDTH  per-lane RAT write enable
rat_wr_idx_o  out  COPY_WIDTH x clog2(ARCH_REGS)  RAT arch index per lane
rat_wr_phys_o  out  COPY_WIDTH x clog2(PHYS_REGS)  phys reg written per lane
flush_o  out  1  one-cycle pipeline flush pulse
commit_stall_o  out  1  ROB must hold its head; commits are ignored while high
busy_o  out  1  recovery in progress
done_o  out  1  one-cycle pulse when recovery completes

Behaviour:
- Reset: asynchronous and active-high. Forces state to IDLE and the chunk counter to 0. While reset is high, every output is 0, including amt_commit_valid_o, and the async reset also aborts any recovery mid-sequence. There is no partial-copy resume.
- FSM states: IDLE, FLUSH, COPY, DONE.
- Commit filter (combinational; active only in IDLE):
  - amt_commit_valid_o[i] = rob_commit_valid_i[i], AND no valid slot j>i has the same arch reg, AND NOT (ZERO_REG_EN and arch==0).
  - When not in IDLE, amt_commit_valid_o = 0.
- IDLE -> FLUSH: on mispredict_i=1 in IDLE. The filtered commit group of that same cycle still goes to the AMT. The ROB guarantees no younger-than-branch slots are valid.
- FLUSH (1 cycle):
  - flush_o=1, commit_stall_o=1, busy_o=1.
  - Chunk counter cleared to 0.
  - Next state is COPY. This cycle lets the AMT absorb the final commit, so amt_snapshot_i is stable from COPY onward.
- COPY (N = ceil(ARCH_REGS/COPY_WIDTH) cycles):
  - Lane k: rat_wr_idx_o[k] = cnt*COPY_WIDTH+k, rat_wr_phys_o[k] = amt_snapshot_i[idx], rat_wr_valid_o[k] = (idx < ARCH_REGS).
  - The partial last chunk masks out-of-range lanes, and their idx/phys outputs are driven 0.
  - cnt increments each cycle. When cnt==N-1, next state is DONE.
  - commit_stall_o=1, busy_o=1.
- DONE (1 cycle): done_o=1, commit_stall_o=1, busy_o=1. Next state is IDLE.
- Outputs are combinational from state and counter. rat_wr_* are zero outside COPY.
- mispredict_i outside IDLE is ignored: it does not restart or extend recovery.
- Total commit stall per recovery is N+2 cycles. The first commit is accepted in the cycle after DONE.
- Counter width is clog2(N)+1. No wrap occurs beyond N-1.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> all outputs 0 immediately, state IDLE. Release, then idle commit of slot0 arch 5 -> phys 70 -> amt_commit_valid_o=01 in the same cycle.
- WAW filter: slot0 arch 3->p40, slot1 arch 3->p41, both valid -> amt_commit_valid_o=10. Also slot0 arch 0 with ZERO_REG_EN=1 -> that slot is dropped.
- Full recovery (ARCH_REGS=64, COPY_WIDTH=8), AMT identity map with arch 7 -> p99:
  - Pulse mispredict_i with slot0 commit arch 7->p99 -> that commit passes.
  - flush_o high for exactly 1 cycle.
  - 8 COPY cycles, all lanes valid, indices 0..63 each written exactly once, index 7 carries p99.
  - done_o high for 1 cycle.
  - commit_stall_o high for exactly 10 cycles.
- Partial chunk (ARCH_REGS=64, COPY_WIDTH=6) -> 11 COPY cycles. In the last cycle only lanes 0..3 are valid (idx 60..63) and lanes 4..5 are 0.
- Mispredict during COPY with commit valids asserted -> no restart, amt_commit_valid_o stays 0, done_o arrives at the same cycle as without the extra mispredict.
- Reset asserted in COPY cycle 3 -> rat_wr_valid_o=0 and busy_o=0 immediately. After release, a new mispredict runs a complete 8-chunk copy from idx 0.
